// File: rtl/pet2001keymatrix_if.sv
// pet2001keymatrix_if: keyboard-side signal bundle between the HPS PS/2 channel,
// the PET I/O block and the key matrix.
//   ps2_key   [10:0] HPS key event (bit 10 toggles per event, 9 = press, 8 = E0, 7:0 code)
//   keyrow    [3:0]  row select from PIA1 port A[3:0]
//   key_reset        clears every key while high
//   keyin     [7:0]  active-low column byte for the selected row
// master: the side that produces events/row select; slave: the key matrix.
interface pet2001keymatrix_if;
    logic [10:0] ps2_key;
    logic [3:0]  keyrow;
    logic        key_reset;
    logic [7:0]  keyin;

    modport master (
        output ps2_key,
        output keyrow,
        output key_reset,
        input  keyin
    );

    modport slave (
        input  ps2_key,
        input  keyrow,
        input  key_reset,
        output keyin
    );
endinterface

// File: rtl/pet2001keymatrix.sv
// pet2001keymatrix: PS/2 set-2 key events -> PET 2001 10x8 keyboard matrix.
//   clk        system clock
//   reset      synchronous, active-high
//   bus        pet2001keymatrix_if.slave (ps2_key, keyrow, key_reset in; keyin out)
// Parameter ROWS: implemented matrix rows; rows ROWS..15 always read 8'hFF.
// Optional macro PET_KEY_GHOST_EN: one-hop matrix ghosting on the read port.
// Event path: S0 detect -> S1 translate -> S2 update, then a registered row read.
module pet2001keymatrix #(
    parameter int unsigned ROWS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    pet2001keymatrix_if.slave    bus
);

    localparam int unsigned MAX_ROWS = 16;
    localparam int unsigned ROW_W    = 4;
    localparam int unsigned COL_W    = 3;
    localparam int unsigned COLS     = 8;
    localparam int unsigned EVT_W    = 10;
    localparam logic [ROW_W:0] ROWS_LIM = (ROW_W + 1)'(ROWS);

    // Translated key position
    typedef struct packed {
        logic             hit;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } xlate_t;

    // ------------------------------------------------------------------
    // Scancode ROM: {ext, code} -> PET graphics-keyboard matrix position.
    // Keypad codes and unlisted extended codes are deliberately unmapped.
    // ------------------------------------------------------------------
    function automatic xlate_t rom_lookup(input logic ext, input logic [7:0] code);
        xlate_t x;
        x = '{hit: 1'b0, row: '0, col: '0};
        unique case ({ext, code})
            // row 0: ! # % & ( <- HOME CRSR-RIGHT
            9'h00E: x = '{hit: 1'b1, row: 4'd0, col: 3'd5};
            9'h16C: x = '{hit: 1'b1, row: 4'd0, col: 3'd6};
            9'h174: x = '{hit: 1'b1, row: 4'd0, col: 3'd7};
            // row 1: " $ ' \ ) - DEL CRSR-DOWN
            9'h052: x = '{hit: 1'b1, row: 4'd1, col: 3'd2};
            9'h05D: x = '{hit: 1'b1, row: 4'd1, col: 3'd3};
            9'h066: x = '{hit: 1'b1, row: 4'd1, col: 3'd6};
            9'h171: x = '{hit: 1'b1, row: 4'd1, col: 3'd6};
            9'h172: x = '{hit: 1'b1, row: 4'd1, col: 3'd7};
            // row 2: Q E T U O ^ 7 9
            9'h015: x = '{hit: 1'b1, row: 4'd2, col: 3'd0};
            9'h024: x = '{hit: 1'b1, row: 4'd2, col: 3'd1};
            9'h02C: x = '{hit: 1'b1, row: 4'd2, col: 3'd2};
            9'h03C: x = '{hit: 1'b1, row: 4'd2, col: 3'd3};
            9'h044: x = '{hit: 1'b1, row: 4'd2, col: 3'd4};
            9'h03D: x = '{hit: 1'b1, row: 4'd2, col: 3'd6};
            9'h046: x = '{hit: 1'b1, row: 4'd2, col: 3'd7};
            // row 3: W R Y I P - 8 /
            9'h01D: x = '{hit: 1'b1, row: 4'd3, col: 3'd0};
            9'h02D: x = '{hit: 1'b1, row: 4'd3, col: 3'd1};
            9'h035: x = '{hit: 1'b1, row: 4'd3, col: 3'd2};
            9'h043: x = '{hit: 1'b1, row: 4'd3, col: 3'd3};
            9'h04D: x = '{hit: 1'b1, row: 4'd3, col: 3'd4};
            9'h03E: x = '{hit: 1'b1, row: 4'd3, col: 3'd6};
            9'h04A: x = '{hit: 1'b1, row: 4'd3, col: 3'd7};
            // row 4: A D G J L - 4 6
            9'h01C: x = '{hit: 1'b1, row: 4'd4, col: 3'd0};
            9'h023: x = '{hit: 1'b1, row: 4'd4, col: 3'd1};
            9'h034: x = '{hit: 1'b1, row: 4'd4, col: 3'd2};
            9'h03B: x = '{hit: 1'b1, row: 4'd4, col: 3'd3};
            9'h04B: x = '{hit: 1'b1, row: 4'd4, col: 3'd4};
            9'h025: x = '{hit: 1'b1, row: 4'd4, col: 3'd6};
            9'h036: x = '{hit: 1'b1, row: 4'd4, col: 3'd7};
            // row 5: S F H K : - 5 *
            9'h01B: x = '{hit: 1'b1, row: 4'd5, col: 3'd0};
            9'h02B: x = '{hit: 1'b1, row: 4'd5, col: 3'd1};
            9'h033: x = '{hit: 1'b1, row: 4'd5, col: 3'd2};
            9'h042: x = '{hit: 1'b1, row: 4'd5, col: 3'd3};
            9'h02E: x = '{hit: 1'b1, row: 4'd5, col: 3'd6};
            // row 6: Z C B M ; RETURN 1 3
            9'h01A: x = '{hit: 1'b1, row: 4'd6, col: 3'd0};
            9'h021: x = '{hit: 1'b1, row: 4'd6, col: 3'd1};
            9'h032: x = '{hit: 1'b1, row: 4'd6, col: 3'd2};
            9'h03A: x = '{hit: 1'b1, row: 4'd6, col: 3'd3};
            9'h04C: x = '{hit: 1'b1, row: 4'd6, col: 3'd4};
            9'h05A: x = '{hit: 1'b1, row: 4'd6, col: 3'd5};
            9'h016: x = '{hit: 1'b1, row: 4'd6, col: 3'd6};
            9'h026: x = '{hit: 1'b1, row: 4'd6, col: 3'd7};
            // row 7: X V N , ? - 2 +
            9'h022: x = '{hit: 1'b1, row: 4'd7, col: 3'd0};
            9'h02A: x = '{hit: 1'b1, row: 4'd7, col: 3'd1};
            9'h031: x = '{hit: 1'b1, row: 4'd7, col: 3'd2};
            9'h041: x = '{hit: 1'b1, row: 4'd7, col: 3'd3};
            9'h01E: x = '{hit: 1'b1, row: 4'd7, col: 3'd6};
            // row 8: LSHIFT @ ] - > RSHIFT 0 -
            9'h012: x = '{hit: 1'b1, row: 4'd8, col: 3'd0};
            9'h05B: x = '{hit: 1'b1, row: 4'd8, col: 3'd2};
            9'h059: x = '{hit: 1'b1, row: 4'd8, col: 3'd5};
            9'h045: x = '{hit: 1'b1, row: 4'd8, col: 3'd6};
            9'h04E: x = '{hit: 1'b1, row: 4'd8, col: 3'd7};
            // row 9: RVS [ SPACE < STOP - . =
            9'h00D: x = '{hit: 1'b1, row: 4'd9, col: 3'd0};
            9'h054: x = '{hit: 1'b1, row: 4'd9, col: 3'd1};
            9'h029: x = '{hit: 1'b1, row: 4'd9, col: 3'd2};
            9'h076: x = '{hit: 1'b1, row: 4'd9, col: 3'd4};
            9'h049: x = '{hit: 1'b1, row: 4'd9, col: 3'd6};
            9'h055: x = '{hit: 1'b1, row: 4'd9, col: 3'd7};
            default: x = '{hit: 1'b0, row: '0, col: '0};
        endcase
        return x;
    endfunction

    // ------------------------------------------------------------------
    // S0: capture event and detect the toggle
    // ------------------------------------------------------------------
    logic [EVT_W-1:0] k_q;
    logic             tog_q;
    logic             s0_vld_q;
    logic             s0_vld_d;

    assign s0_vld_d = bus.ps2_key[10] != tog_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q      <= '0;
            tog_q    <= bus.ps2_key[10];
            s0_vld_q <= 1'b0;
        end else begin
            k_q      <= bus.ps2_key[EVT_W-1:0];
            tog_q    <= bus.ps2_key[10];
            s0_vld_q <= s0_vld_d;
        end
    end

    // ------------------------------------------------------------------
    // S1: ROM translate
    // ------------------------------------------------------------------
    xlate_t xl_d;
    xlate_t s1_xl_q;
    logic   s1_vld_q;
    logic   s1_press_q;

    assign xl_d = rom_lookup(k_q[8], k_q[7:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q   <= 1'b0;
            s1_press_q <= 1'b0;
            s1_xl_q    <= '0;
        end else begin
            s1_vld_q   <= s0_vld_q;
            s1_press_q <= k_q[9];
            s1_xl_q    <= xl_d;
        end
    end

    // ------------------------------------------------------------------
    // S2: matrix write command; unmapped codes are dropped here
    // ------------------------------------------------------------------
    logic             s2_vld_q;
    logic             s2_vld_d;
    logic             s2_press_q;
    logic [ROW_W-1:0] s2_row_q;
    logic [COL_W-1:0] s2_col_q;

    assign s2_vld_d = s1_vld_q && s1_xl_q.hit && ({1'b0, s1_xl_q.row} < ROWS_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_vld_q   <= 1'b0;
            s2_press_q <= 1'b0;
            s2_row_q   <= '0;
            s2_col_q   <= '0;
        end else begin
            s2_vld_q   <= s2_vld_d;
            s2_press_q <= s1_press_q;
            s2_row_q   <= s1_xl_q.row;
            s2_col_q   <= s1_xl_q.col;
        end
    end

    // ------------------------------------------------------------------
    // Key-state matrix (1 = down). Clear wins over a same-cycle write;
    // rows at or above ROWS are never written and stay zero.
    // ------------------------------------------------------------------
    logic [MAX_ROWS-1:0][COLS-1:0] m_q;

    always_ff @(posedge clk) begin
        if (reset || bus.key_reset) begin
            m_q <= '0;
        end else if (s2_vld_q) begin
            m_q[s2_row_q][s2_col_q] <= s2_press_q;
        end
    end

    // ------------------------------------------------------------------
    // Column bits of the selected row, read from the pre-write matrix
    // ------------------------------------------------------------------
    logic [COLS-1:0] colbits_c;

`ifdef PET_KEY_GHOST_EN
    // Each row also picks up every other row that shares a pressed column.
    logic [MAX_ROWS-1:0][COLS-1:0] ghost_c;

    always_comb begin
        ghost_c = '0;
        for (int unsigned r = 0; r < MAX_ROWS; r++) begin
            ghost_c[ROW_W'(r)] = m_q[ROW_W'(r)];
            for (int unsigned j = 0; j < ROWS; j++) begin
                if ((j != r) && ((m_q[ROW_W'(j)] & m_q[ROW_W'(r)]) != '0)) begin
                    ghost_c[ROW_W'(r)] = ghost_c[ROW_W'(r)] | m_q[ROW_W'(j)];
                end
            end
        end
    end

    assign colbits_c = ghost_c[bus.keyrow];
`else
    assign colbits_c = m_q[bus.keyrow];
`endif

    // ------------------------------------------------------------------
    // Registered active-low read port
    // ------------------------------------------------------------------
    logic [COLS-1:0] keyin_q;
    logic [COLS-1:0] keyin_d;

    assign keyin_d = ({1'b0, bus.keyrow} < ROWS_LIM) ? ~colbits_c : 8'hFF;

    always_ff @(posedge clk) begin
        if (reset) begin
            keyin_q <= 8'hFF;
        end else begin
            keyin_q <= keyin_d;
        end
    end

    assign bus.keyin = keyin_q;

endmodule

// File: tb/tb_pet2001keymatrix.sv
// Self-checking bench for pet2001keymatrix: directed scenarios plus random
// event traffic, compared each cycle against a queue-based reference model.
module tb_pet2001keymatrix;

    localparam int unsigned ROWS = 10;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pet2001keymatrix_if bus();

    pet2001keymatrix #(.ROWS(ROWS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%02h exp=%02h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int due;
        int idx;
        bit press;
    } pend_t;

    logic [7:0] ref_m [16];
    logic       ref_tog;
    logic [7:0] ref_keyin;
    int         cyc;
    pend_t      pend_q[$];
    int         map_aa [int];
    int         map_keys[$];
    logic [10:0] cur_pk;

    task automatic add_map(input int key, input int row, input int col);
        map_aa[key] = row * 8 + col;
        map_keys.push_back(key);
    endtask

    task automatic build_map();
        add_map('h00E, 0, 5); add_map('h16C, 0, 6); add_map('h174, 0, 7);
        add_map('h052, 1, 2); add_map('h05D, 1, 3); add_map('h066, 1, 6);
        add_map('h171, 1, 6); add_map('h172, 1, 7);
        add_map('h015, 2, 0); add_map('h024, 2, 1); add_map('h02C, 2, 2);
        add_map('h03C, 2, 3); add_map('h044, 2, 4); add_map('h03D, 2, 6);
        add_map('h046, 2, 7);
        add_map('h01D, 3, 0); add_map('h02D, 3, 1); add_map('h035, 3, 2);
        add_map('h043, 3, 3); add_map('h04D, 3, 4); add_map('h03E, 3, 6);
        add_map('h04A, 3, 7);
        add_map('h01C, 4, 0); add_map('h023, 4, 1); add_map('h034, 4, 2);
        add_map('h03B, 4, 3); add_map('h04B, 4, 4); add_map('h025, 4, 6);
        add_map('h036, 4, 7);
        add_map('h01B, 5, 0); add_map('h02B, 5, 1); add_map('h033, 5, 2);
        add_map('h042, 5, 3); add_map('h02E, 5, 6);
        add_map('h01A, 6, 0); add_map('h021, 6, 1); add_map('h032, 6, 2);
        add_map('h03A, 6, 3); add_map('h04C, 6, 4); add_map('h05A, 6, 5);
        add_map('h016, 6, 6); add_map('h026, 6, 7);
        add_map('h022, 7, 0); add_map('h02A, 7, 1); add_map('h031, 7, 2);
        add_map('h041, 7, 3); add_map('h01E, 7, 6);
        add_map('h012, 8, 0); add_map('h05B, 8, 2); add_map('h059, 8, 5);
        add_map('h045, 8, 6); add_map('h04E, 8, 7);
        add_map('h00D, 9, 0); add_map('h054, 9, 1); add_map('h029, 9, 2);
        add_map('h076, 9, 4); add_map('h049, 9, 6); add_map('h055, 9, 7);
    endtask

    function automatic logic [7:0] ref_cols(input int r);
        logic [7:0] acc;
        acc = ref_m[r];
`ifdef PET_KEY_GHOST_EN
        for (int j = 0; j < int'(ROWS); j++) begin
            if (j != r && (ref_m[j] & ref_m[r]) != 8'h00) acc = acc | ref_m[j];
        end
`endif
        return acc;
    endfunction

    // One clock edge of the model, using the inputs present at that edge.
    task automatic ref_edge();
        logic [7:0] nxt;
        pend_t      p;
        int         key;
        nxt = (int'(bus.keyrow) >= int'(ROWS)) ? 8'hFF : ~ref_cols(int'(bus.keyrow));
        if (reset) begin
            for (int i = 0; i < 16; i++) ref_m[i] = 8'h00;
            pend_q.delete();
            ref_keyin = 8'hFF;
        end else begin
            ref_keyin = nxt;
            while (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                p = pend_q.pop_front();
                if (!bus.key_reset) ref_m[p.idx / 8][p.idx % 8] = p.press;
            end
            if (bus.key_reset) begin
                for (int i = 0; i < 16; i++) ref_m[i] = 8'h00;
            end
            if (bus.ps2_key[10] != ref_tog) begin
                key = int'(bus.ps2_key[8:0]);
                if (map_aa.exists(key)) begin
                    p.due   = cyc + 3;
                    p.idx   = map_aa[key];
                    p.press = bus.ps2_key[9];
                    pend_q.push_back(p);
                end
            end
        end
        ref_tog = bus.ps2_key[10];
        cyc++;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic [3:0] row, input bit kr, input bit rst);
        bus.ps2_key   = cur_pk;
        bus.keyrow    = row;
        bus.key_reset = kr;
        reset         = rst;
        @(posedge clk);
        ref_edge();
        @(negedge clk);
        check_eq($sformatf("keyin_r%0d", row), bus.keyin, ref_keyin);
    endtask

    task automatic ev(input bit press, input bit ext, input logic [7:0] code, input logic [3:0] row);
        cur_pk = {~cur_pk[10], press, ext, code};
        step(row, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input logic [3:0] row);
        for (int i = 0; i < n; i++) step(row, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int   r;
        int   key;
        bit   press;
        build_map();
        cur_pk        = '0;
        reset         = 1'b1;
        bus.ps2_key   = '0;
        bus.keyrow    = '0;
        bus.key_reset = 1'b0;
        ref_tog       = 1'b0;
        ref_keyin     = 8'hFF;
        cyc           = 0;
        for (int i = 0; i < 16; i++) ref_m[i] = 8'h00;
        @(negedge clk);

        // reset and full row sweep
        step(4'd0, 1'b0, 1'b1);
        step(4'd0, 1'b0, 1'b1);
        check_eq("reset_keyin", bus.keyin, 8'hFF);
        for (int i = 0; i < 16; i++) step(4'(i), 1'b0, 1'b0);

        // press A: visible exactly 4 edges after the toggle
        ev(1'b1, 1'b0, 8'h1C, 4'd4);
        idle(3, 4'd4);
        check_eq("a_edge3", bus.keyin, 8'hFF);
        idle(1, 4'd4);
        check_eq("a_edge4", bus.keyin, 8'hFE);
        step(4'd3, 1'b0, 1'b0);
        check_eq("a_row3", bus.keyin, 8'hFF);
        step(4'd4, 1'b0, 1'b0);
        check_eq("a_repeat", bus.keyin, 8'hFE);
        ev(1'b0, 1'b0, 8'h1C, 4'd4);
        idle(4, 4'd4);
        check_eq("a_release", bus.keyin, 8'hFF);

        // extended vs plain 0x74
        ev(1'b1, 1'b1, 8'h74, 4'd0);
        idle(4, 4'd0);
        check_eq("e0_74", bus.keyin, 8'h7F);
        ev(1'b0, 1'b1, 8'h74, 4'd0);
        idle(4, 4'd0);
        ev(1'b1, 1'b0, 8'h74, 4'd0);
        idle(4, 4'd0);
        check_eq("plain_74", bus.keyin, 8'hFF);

        // back-to-back events
        ev(1'b1, 1'b0, 8'h12, 4'd8);
        ev(1'b1, 1'b0, 8'h29, 4'd8);
        idle(4, 4'd8);
        check_eq("b2b_row8", bus.keyin, 8'hFE);
        step(4'd9, 1'b0, 1'b0);
        step(4'd9, 1'b0, 1'b0);
        check_eq("b2b_row9", bus.keyin, 8'hFB);

        // key_reset on the same edge as a pending matrix write
        ev(1'b1, 1'b0, 8'h1C, 4'd4);
        idle(2, 4'd4);
        step(4'd4, 1'b1, 1'b0);
        idle(4, 4'd4);
        check_eq("kr_row4", bus.keyin, 8'hFF);
        for (int i = 0; i < 16; i++) step(4'(i), 1'b0, 1'b0);

        // ghosting
        ev(1'b1, 1'b0, 8'h1C, 4'd4);
        ev(1'b1, 1'b0, 8'h12, 4'd4);
        ev(1'b1, 1'b0, 8'h59, 4'd4);
        idle(5, 4'd4);
`ifdef PET_KEY_GHOST_EN
        check_eq("ghost_row4", bus.keyin, 8'hDE);
`else
        check_eq("ghost_row4", bus.keyin, 8'hFE);
`endif

        // reset mid-pipeline discards in-flight events
        ev(1'b1, 1'b0, 8'h29, 4'd9);
        step(4'd9, 1'b0, 1'b1);
        idle(5, 4'd9);
        check_eq("rst_mid", bus.keyin, 8'hFF);

        // all keys down, out-of-range rows
        foreach (map_keys[i]) begin
            cur_pk = {~cur_pk[10], 1'b1, 9'(map_keys[i])};
            step(4'(i % 16), 1'b0, 1'b0);
        end
        idle(5, 4'd12);
        check_eq("row12_all", bus.keyin, 8'hFF);
        step(4'd15, 1'b0, 1'b0);
        check_eq("row15_all", bus.keyin, 8'hFF);
        for (int i = 0; i < 16; i++) step(4'(i), 1'b0, 1'b0);
        step(4'd0, 1'b1, 1'b0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40) begin
                if ($urandom_range(0, 3) != 0) key = map_keys[$urandom_range(0, map_keys.size() - 1)];
                else key = int'($urandom_range(0, 511));
                press = ($urandom_range(0, 9) < 6);
                cur_pk = {~cur_pk[10], press, 9'(key)};
            end
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 199) == 0), ($urandom_range(0, 499) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
